// File: rtl/mc68681_pkg.sv
// mc68681_pkg: shared definitions for the MC68681 DUART bus master.
//   - state_e       : bus-cycle FSM states
//   - register map  : DUART register address constants (A3..A0)
//   - cnt_width()   : counter width derived from the largest cycle count
package mc68681_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  // DUART register map
  localparam logic [3:0] MR_A      = 4'd0;
  localparam logic [3:0] SR_CSR_A  = 4'd1;
  localparam logic [3:0] CR_A      = 4'd2;
  localparam logic [3:0] RB_TB_A   = 4'd3;
  localparam logic [3:0] IPCR_ACR  = 4'd4;
  localparam logic [3:0] ISR_IMR   = 4'd5;
  localparam logic [3:0] CTUR      = 4'd6;
  localparam logic [3:0] CTLR      = 4'd7;
  localparam logic [3:0] MR_B      = 4'd8;
  localparam logic [3:0] SR_CSR_B  = 4'd9;
  localparam logic [3:0] CR_B      = 4'd10;
  localparam logic [3:0] RB_TB_B   = 4'd11;
  localparam logic [3:0] IVR       = 4'd12;
  localparam logic [3:0] IP_OPCR   = 4'd13;
  localparam logic [3:0] START_SET = 4'd14;
  localparam logic [3:0] STOP_CLR  = 4'd15;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..maxv (at least 1).
  function automatic int cnt_width(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/mc68681_sync2.sv
// mc68681_sync2: two-flop synchroniser for an active-low asynchronous input.
// Both flops reset to 1 (the inactive level of the synchronised signal).
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output (2-cycle latency)
module mc68681_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/mc68681_bus_master.sv
// mc68681_bus_master: host-side bus initiator for the MC68681 DUART.
// Turns one valid/ready request into a register cycle with programmable
// setup / strobe / hold / recovery, returns a one-cycle response strobe,
// and synchronises _INT into an active-high irq.
//
// Host side : req_valid/req_ready/req_rw/req_addr/req_wdata,
//             rsp_valid/rsp_rdata/rsp_err
// Bus side  : A0..A3, R_W, _CS, DATA_OUT, DATA_OE, DATA_IN, _INT
// Misc      : CLK, _RESET (async active low), irq
//
// Optional build macro MC68681_BUS_DTACK_EN: adds the _DTACK input; STROBE
// is then extended until _DTACK is seen low, capped at DTACK_TIMEOUT extra
// cycles, with rsp_err flagging a timeout. Without it rsp_err is always 0.
module mc68681_bus_master #(
  parameter int SETUP_CYC     = 1,
  parameter int STROBE_CYC    = 2,
  parameter int HOLD_CYC      = 1,
  parameter int RECOVERY_CYC  = 2,
  parameter int DTACK_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       _RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       R_W,
  output logic       _CS,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  input  logic [7:0] DATA_IN,
  input  logic       _INT,
`ifdef MC68681_BUS_DTACK_EN
  input  logic       _DTACK,
`endif
  output logic       irq
);

  import mc68681_pkg::*;

  // Counter counts cycles spent in the current state (0-based); the strobe
  // may run for STROBE_CYC + DTACK_TIMEOUT cycles in the extended build.
  localparam int CNT_MAX = max2(max2(SETUP_CYC - 1, HOLD_CYC - 1),
                                max2(RECOVERY_CYC - 1, STROBE_CYC - 1 + DTACK_TIMEOUT));
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOVERY_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       addr_q, addr_d;
  logic             rw_q, rw_d;
  logic [7:0]       dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             cs_n_q, cs_n_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             tmo_q, tmo_d;     // last strobe ended by timeout
  logic             strobe_done, strobe_tmo;
  logic             int_n_s;

  // ---------------------------------------------------------------------
  // Strobe termination
  // ---------------------------------------------------------------------
`ifdef MC68681_BUS_DTACK_EN
  localparam logic [CNT_W-1:0] STB_MAX = CNT_W'(STROBE_CYC - 1 + DTACK_TIMEOUT);
  logic dtack_n_s;

  mc68681_sync2 u_sync_dtack (
    .clk_i  (CLK),
    .rst_ni (_RESET),
    .d_i    (_DTACK),
    .q_o    (dtack_n_s)
  );

  // Minimum width first, then wait for DTACK or the cap. Ending at the cap
  // while DTACK is still high is the timeout case.
  assign strobe_done = (cnt_q >= STB_LAST) && (!dtack_n_s || (cnt_q == STB_MAX));
  assign strobe_tmo  = dtack_n_s;
`else
  assign strobe_done = (cnt_q == STB_LAST);
  assign strobe_tmo  = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM next-state and registered-output next values
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          state_d = ST_SETUP;
          addr_d  = req_addr;
          rw_d    = req_rw;
          oe_d    = ~req_rw;
          tmo_d   = 1'b0;
          if (!req_rw) dout_d = req_wdata;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end
      end
      ST_STROBE: begin
        if (strobe_done) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          tmo_d   = strobe_tmo;
          if (rw_q) rdata_d = DATA_IN;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
          oe_d    = 1'b0;
          rw_d    = 1'b1;
          vld_d   = 1'b1;
          err_d   = tmo_q;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == RECOV_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Chip select and ready follow the state being entered so they are
    // registered yet aligned with the state.
    cs_n_d = (state_d != ST_STROBE);
    rdy_d  = (state_d == ST_IDLE);
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= 4'h0;
      rw_q    <= 1'b1;
      dout_q  <= 8'h00;
      oe_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      cs_n_q  <= cs_n_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt synchroniser (independent of the FSM)
  // ---------------------------------------------------------------------
  mc68681_sync2 u_sync_int (
    .clk_i  (CLK),
    .rst_ni (_RESET),
    .d_i    (_INT),
    .q_o    (int_n_s)
  );

  assign irq       = ~int_n_s;
  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign A0        = addr_q[0];
  assign A1        = addr_q[1];
  assign A2        = addr_q[2];
  assign A3        = addr_q[3];
  assign R_W       = rw_q;
  assign _CS       = cs_n_q;
  assign DATA_OUT  = dout_q;
  assign DATA_OE   = oe_q;

endmodule

// File: tb/tb_mc68681_bus_master.sv
// tb_mc68681_bus_master: randomized self-checking bench for mc68681_bus_master.
// A cycle-position model (cycles since acceptance) predicts every output.
module tb_mc68681_bus_master;
  import mc68681_pkg::*;

  localparam int S   = 1;
  localparam int B0  = 2;
  localparam int H   = 1;
  localparam int R   = 2;
  localparam int TMO = 255;
`ifdef MC68681_BUS_DTACK_EN
  localparam int B    = B0 + TMO;  // _DTACK held high: every strobe times out
  localparam bit ERR  = 1'b1;
  localparam int NCYC = 4000;
`else
  localparam int B    = B0;
  localparam bit ERR  = 1'b0;
  localparam int NCYC = 3000;
`endif
  localparam int T_RSP = S + B + H + 1;
  localparam int T_TOT = S + B + H + R;

  logic       CLK = 1'b0;
  logic       _RESET;
  logic       req_valid, req_ready, req_rw;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       A0, A1, A2, A3, R_W, _CS, DATA_OE;
  logic [7:0] DATA_OUT, DATA_IN;
  logic       _INT, irq;
`ifdef MC68681_BUS_DTACK_EN
  logic       _DTACK;
`endif

  always #5 CLK = ~CLK;

  mc68681_bus_master #(
    .SETUP_CYC(S), .STROBE_CYC(B0), .HOLD_CYC(H), .RECOVERY_CYC(R), .DTACK_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), ._RESET(_RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .R_W(R_W), ._CS(_CS),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
    ._INT(_INT),
`ifdef MC68681_BUS_DTACK_EN
    ._DTACK(_DTACK),
`endif
    .irq(irq)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       rw;
    logic [3:0] a;
    logic [7:0] wd;
    logic [7:0] sd;   // value the "DUART" drives during strobe of a read
  } req_t;

  req_t       q[$];
  req_t       cur;
  bit         pend;
  int         rel;      // posedges since acceptance (1 = first SETUP cycle)
  logic       t_rw;
  logic [3:0] t_addr;
  logic [7:0] t_sd, exp_dout, exp_rdata;
  logic       ih0, ih1; // _INT driven one and two cycles back

  task automatic model_reset();
    rel = 1000; t_rw = 1'b1; t_addr = 4'h0; t_sd = 8'h00;
    exp_dout = 8'h00; exp_rdata = 8'h00; ih0 = 1'b1; ih1 = 1'b1; pend = 1'b0;
  endtask

  task automatic check_cycle();
    bit act, stb;
    act = (rel >= 1) && (rel <= S + B + H);
    stb = (rel >= S + 1) && (rel <= S + B);
    chk("req_ready", req_ready, rel > T_TOT);
    chk("cs_n", _CS, !stb);
    chk("data_oe", DATA_OE, act && !t_rw);
    chk("r_w", R_W, !(act && !t_rw));
    chk("rsp_valid", rsp_valid, rel == T_RSP);
    chk("addr", {A3, A2, A1, A0}, t_addr);
    chk("data_out", DATA_OUT, exp_dout);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, (rel == T_RSP) && ERR);
    chk("irq", irq, !ih1);
  endtask

  initial begin
    bit idle_m, stb, did_rst;
    int ntx;
    ntx = 0; did_rst = 1'b0;
    _RESET = 1'b0; req_valid = 1'b0; req_rw = 1'b1; req_addr = 4'h0; req_wdata = 8'h00;
    DATA_IN = 8'hFF; _INT = 1'b1;
`ifdef MC68681_BUS_DTACK_EN
    _DTACK = 1'b1;
`endif
    model_reset();
    repeat (3) @(negedge CLK);
    check_cycle();               // reset values while in reset
    _RESET = 1'b1;
    repeat (20) begin            // idle, no requests: _CS stays high
      @(negedge CLK);
      check_cycle();
    end

    q.push_back('{rw: 1'b0, a: RB_TB_A,  wd: 8'hA5, sd: 8'h00});
    q.push_back('{rw: 1'b1, a: SR_CSR_A, wd: 8'h00, sd: 8'h5C});
    q.push_back('{rw: 1'b0, a: CR_A,     wd: 8'h3C, sd: 8'h00});
    q.push_back('{rw: 1'b0, a: IVR,      wd: 8'h0F, sd: 8'h00});

    for (int c = 0; c < NCYC; c++) begin
      check_cycle();

      // Abort a cycle mid-strobe with an asynchronous reset.
      if (!did_rst && ntx >= 6 && rel == S + 1) begin
        _RESET = 1'b0; req_valid = 1'b0; _INT = 1'b1;
        #1;
        chk("rst_cs_n", _CS, 1'b1);
        chk("rst_oe", DATA_OE, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        model_reset();
        @(negedge CLK);
        check_cycle();
        _RESET = 1'b1;
        did_rst = 1'b1;
        continue;
      end

      // Bus-side stimulus for this cycle.
      stb = (rel >= S + 1) && (rel <= S + B);
      DATA_IN = (stb && t_rw) ? t_sd : 8'hFF;
      ih1 = ih0;
      if ($urandom_range(0, 3) == 0) _INT = 1'($urandom_range(0, 1));
      ih0 = _INT;

      // Host: present a request and hold it until accepted.
      if (!pend && (q.size() > 0 || $urandom_range(0, 3) != 0)) begin
        if (q.size() > 0) cur = q.pop_front();
        else begin
          cur.rw = 1'($urandom_range(0, 1));
          cur.a  = 4'($urandom);
          cur.wd = 8'($urandom);
          cur.sd = 8'($urandom);
        end
        pend = 1'b1;
      end
      req_valid = pend;
      if (pend) begin
        req_rw = cur.rw; req_addr = cur.a; req_wdata = cur.wd;
      end else begin
        req_rw = 1'($urandom_range(0, 1)); req_addr = 4'($urandom); req_wdata = 8'($urandom);
      end

      idle_m = rel > T_TOT;
      @(posedge CLK);
      if (pend && idle_m) begin
        t_rw = cur.rw; t_addr = cur.a; t_sd = cur.sd;
        if (!cur.rw) exp_dout = cur.wd;
        rel = 0; pend = 1'b0; ntx++;
      end
      if (rel < 1000) rel++;
      if (rel == S + B + 1 && t_rw) exp_rdata = t_sd;
      @(negedge CLK);
    end

    chk("txn_count", (ntx > 10), 1'b1);
    chk("reset_abort_done", did_rst, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc68681_bus_master.md
Name: mc68681_bus_master

Overview:
- Host-side bus initiator for the MC68681 DUART register interface.
- Converts a single-request valid/ready handshake into correctly timed register cycles on A0–A3, R_W, _CS and the data bus, with programmable setup, strobe, hold and recovery.
- Returns read data on a one-cycle response strobe.
- Synchronises the DUART's _INT into an active-high irq for the host.

Parameters:
- SETUP_CYC, 1, cycles address/R_W/write data are stable before _CS falls (min 1)
- STROBE_CYC, 2, cycles _CS is held low (min 1)
- HOLD_CYC, 1, cycles address/R_W/write data are held after _CS rises (min 1)
- RECOVERY_CYC, 2, idle cycles enforced between consecutive bus cycles (min 1)
- DTACK_TIMEOUT, 255, max strobe-extension cycles waiting for _DTACK (used only with the optional feature)

Ports:
- CLK  input  1  single system clock, rising edge
- _RESET  input  1  asynchronous, active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  high only in IDLE; the request is accepted on req_valid & req_ready
- req_rw  input  1  1 = read, 0 = write (68k R_W sense)
- req_addr  input  4  register address
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle pulse at completion of every accepted request, read or write
- rsp_rdata  output  8  read data, valid while rsp_valid is high; holds its value until the next read
- rsp_err  output  1  timeout flag, qualified by rsp_valid
- A0, A1, A2, A3  output  1 each  register address to the DUART
- R_W  output  1  bus direction (1 = read)
- _CS  output  1  active-low chip select
- DATA_OUT  output  8  write data driven to the bus
- DATA_OE  output  1  enables DATA_OUT onto the bus
- DATA_IN  input  8  read data from the bus
- _INT  input  1  DUART interrupt, active low, asynchronous
- irq  output  1  synchronised, active-high interrupt

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, A0–A3=0, R_W=1, _CS=1, DATA_OUT=0, DATA_OE=0, irq=0.
- FSM states: IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE.
- IDLE:
  - req_ready=1.
  - On acceptance, latch addr, rw and wdata, then drive A0–A3 and R_W.
  - For a write, also drive DATA_OUT and set DATA_OE=1.
  - Go to SETUP.
- SETUP: lasts SETUP_CYC cycles with _CS=1, then goes to STROBE.
- STROBE:
  - _CS=0 for STROBE_CYC cycles.
  - For a read, DATA_IN is captured into rsp_rdata on the clock edge that ends the last STROBE cycle.
- HOLD: _CS=1; address, R_W and DATA_OE are unchanged for HOLD_CYC cycles.
- RECOVER:
  - Entry: DATA_OE=0, R_W=1, and rsp_valid pulses in the first RECOVER cycle.
  - Lasts RECOVERY_CYC cycles, then IDLE.
  - A0–A3 keep their last value.
- Default-parameter timing, acceptance edge = cycle 0:
  - SETUP in cycle 1; STROBE in cycles 2–3; HOLD in cycle 4.
  - rsp_valid in cycle 5; RECOVER in cycles 5–6.
  - req_ready=1 again in cycle 7. Throughput is one request per 7 cycles.
- Only one request is outstanding. req_valid outside IDLE is ignored, and the host must hold the request until it is accepted.
- DATA_OE is never 1 during a read cycle. For writes, DATA_OE=1 spans SETUP through HOLD inclusive.
- _CS is never low in IDLE, SETUP, HOLD or RECOVER.
- An asynchronous _RESET mid-cycle immediately forces the reset values. The aborted request produces no rsp_valid.
- irq path:
  - Two-flop synchroniser on _INT; both flops reset to 1.
  - irq = inverse of the second flop, so irq latency is 2 cycles.
  - The path is independent of the FSM.
- rsp_err is always 0 when the optional feature is absent.

Optional Feature:
- Macro: MC68681_BUS_DTACK_EN.
- Defined:
  - Adds input port _DTACK (1 bit, active low, asynchronous) with a two-flop synchroniser.
  - STROBE lasts at least STROBE_CYC cycles and then extends until the synchronised _DTACK is low, capped at DTACK_TIMEOUT extra cycles.
  - Read data is captured on the edge that ends STROBE.
  - On timeout, STROBE ends, read data is captured anyway and rsp_err=1 with rsp_valid.
- Undefined: no _DTACK port; STROBE is exactly STROBE_CYC cycles; rsp_err is tied 0.

Decomposition:
- Package mc68681_pkg holds:
  - the FSM state enum;
  - register address constants: MR_A=0, SR_CSR_A=1, CR_A=2, RB_TB_A=3, IPCR_ACR=4, ISR_IMR=5, CTUR=6, CTLR=7, MR_B=8, SR_CSR_B=9, CR_B=10, RB_TB_B=11, IVR=12, IP_OPCR=13, START_SET=14, STOP_CLR=15;
  - the counter width, derived from the largest parameter.
- One sub-module, mc68681_sync2: a reset-to-1 two-flop synchroniser, reused for _INT and _DTACK.

Test Plan:
- Reset with req_valid=0: all outputs equal their reset values, and _CS stays 1 for 20 cycles.
- Write addr=4'h3, data=8'hA5, default parameters:
  - A=3, R_W=0 and DATA_OUT=A5/DATA_OE=1 from cycle 1.
  - _CS=0 exactly in cycles 2–3; DATA_OE falls at cycle 5.
  - rsp_valid=1 only in cycle 5; req_ready returns in cycle 7.
- Read addr=4'h1 with DATA_IN=8'h5C during STROBE and 8'hFF otherwise: rsp_rdata=5C at rsp_valid, rsp_err=0, DATA_OE=0 throughout.
- Back-to-back writes with req_valid held high: second acceptance in cycle 7, and at least 2 cycles with _CS=1 between strobes.
- _RESET asserted during STROBE: _CS=1 and DATA_OE=0 immediately; no rsp_valid; the next request completes normally.
- _INT driven low: irq=1 two cycles later. With MC68681_BUS_DTACK_EN defined and _DTACK held high, rsp_valid arrives with rsp_err=1 after 2+255 STROBE cycles.
